// File: rtl/decade_pkg.sv
// Shared types for the decade-step sharing controller: opcodes, BCD limit and the issue-stage record.
// The issue id field is sized for the largest supported channel count (16).
package decade_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_INC   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         ID_W    = 4;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        op_e             op;
        logic [3:0]      data;
    } issue_t;

endpackage

// File: rtl/decade_step.sv
// Combinational BCD decade-step evaluator: count, load, clear, read with 9->0 carry.
// Zero latency; no flow control, the caller presents one op at a time.
module decade_step
    import decade_pkg::*;
(
    input  logic [3:0] s_i,
    input  op_e        op_i,
    input  logic [3:0] ld_data_i,
    output logic [3:0] nxt_o,
    output logic       carry_o
);

    always_comb begin
        nxt_o   = s_i;
        carry_o = 1'b0;
        case (op_i)
            OP_READ: nxt_o = s_i;
            OP_INC: begin
                if (s_i == BCD_MAX) begin
                    nxt_o   = 4'd0;
                    carry_o = 1'b1;
                end else if (s_i > BCD_MAX) begin
                    // Illegal BCD codes (only reachable via LOAD) resync to 0 silently.
                    nxt_o = 4'd0;
                end else begin
                    nxt_o = s_i + 4'd1;
                end
            end
            OP_LOAD:  nxt_o = ld_data_i;
            OP_CLEAR: nxt_o = 4'd0;
            default:  nxt_o = s_i;
        endcase
    end

endmodule

// File: rtl/decade_step_arbiter.sv
// Round-robin sharing of one decade-step evaluator across NREQ counter channels, one op per cycle.
// Grant edge to done edge is 1 cycle; requesters hold req_i until granted, done has no backpressure.
module decade_step_arbiter
    import decade_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [2*NREQ-1:0] op_i,
    input  logic [4*NREQ-1:0] ld_data_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              done_o,
    output logic [IDW-1:0]    done_id_o,
    output logic [3:0]        done_val_o,
    output logic              done_carry_o,
    output logic [4*NREQ-1:0] state_o,
    output logic [NREQ-1:0]   carry_o
);

    logic [NREQ-1:0][3:0] state_q, state_d;
    logic [NREQ-1:0]      carry_q, carry_d;
    logic [IDW-1:0]       rr_q, rr_d;
    issue_t               iss_q, iss_d;
    logic                 done_q, done_d;
    logic [IDW-1:0]       done_id_q, done_id_d;
    logic [3:0]           done_val_q, done_val_d;
    logic                 done_carry_q, done_carry_d;

    logic                 win_vld;
    logic [IDW-1:0]       win_id;
    logic [3:0]           cur_s;
    logic [3:0]           step_nxt;
    logic                 step_carry;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_vld && req_i[(int'(rr_q) + i) % NREQ]) begin
                win_vld = 1'b1;
                win_id  = IDW'((int'(rr_q) + i) % NREQ);
            end
        end
    end

    assign gnt_o = win_vld ? (NREQ'(1) << win_id) : '0;

    always_comb begin
        rr_d  = rr_q;
        iss_d = '0;
        if (win_vld) begin
            rr_d                = (int'(win_id) == NREQ - 1) ? '0 : win_id + IDW'(1);
            iss_d.valid         = 1'b1;
            iss_d.id[IDW-1:0]   = win_id;
            iss_d.op            = op_e'(op_i[2*int'(win_id) +: 2]);
            iss_d.data          = ld_data_i[4*int'(win_id) +: 4];
        end
    end

    always_comb begin
        cur_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (iss_q.id == ID_W'(i)) cur_s = state_q[i];
        end
    end

    decade_step u_step (
        .s_i       (cur_s),
        .op_i      (iss_q.op),
        .ld_data_i (iss_q.data),
        .nxt_o     (step_nxt),
        .carry_o   (step_carry)
    );

    // Writeback; the sticky carry is untouched by READ.
    always_comb begin
        state_d      = state_q;
        carry_d      = carry_q;
        done_d       = iss_q.valid;
        done_id_d    = done_id_q;
        done_val_d   = done_val_q;
        done_carry_d = done_carry_q;
        if (iss_q.valid) begin
            for (int i = 0; i < NREQ; i++) begin
                if (iss_q.id == ID_W'(i)) begin
                    state_d[i] = step_nxt;
                    if (iss_q.op != OP_READ) carry_d[i] = step_carry;
                end
            end
            done_id_d    = iss_q.id[IDW-1:0];
            done_val_d   = step_nxt;
            done_carry_d = step_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= '0;
            carry_q      <= '0;
            rr_q         <= '0;
            iss_q        <= '0;
            done_q       <= 1'b0;
            done_id_q    <= '0;
            done_val_q   <= '0;
            done_carry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            carry_q      <= carry_d;
            rr_q         <= rr_d;
            iss_q        <= iss_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            done_val_q   <= done_val_d;
            done_carry_q <= done_carry_d;
        end
    end

    assign done_o       = done_q;
    assign done_id_o    = done_id_q;
    assign done_val_o   = done_val_q;
    assign done_carry_o = done_carry_q;
    assign state_o      = state_q;
    assign carry_o      = carry_q;

endmodule

// File: tb/tb_decade_step_arbiter.sv
// Bench for decade_step_arbiter: cycle model of channels/pointer/pending op plus directed scenarios.
module tb_decade_step_arbiter;
    import decade_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [2*N-1:0] op_i = '0;
    logic [4*N-1:0] ld_data_i = '0;
    logic [N-1:0]   gnt_o;
    logic           done_o;
    logic [1:0]     done_id_o;
    logic [3:0]     done_val_o;
    logic           done_carry_o;
    logic [4*N-1:0] state_o;
    logic [N-1:0]   carry_o;

    always #5 clk = ~clk;

    decade_step_arbiter #(.NREQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .op_i         (op_i),
        .ld_data_i    (ld_data_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .done_id_o    (done_id_o),
        .done_val_o   (done_val_o),
        .done_carry_o (done_carry_o),
        .state_o      (state_o),
        .carry_o      (carry_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the registered outputs must show, plus the op accepted but not yet completed.
    int m_state[N];
    bit m_carry[N];
    int m_rr;
    bit m_done;
    int m_done_id, m_done_val;
    bit m_done_carry;
    bit p_vld;
    int p_id, p_op, p_data;

    int log_id[$];
    int log_val[$];
    int log_carry[$];

    function automatic void bcd_eval(input int s, input int op, input int data,
                                     output int nxt, output bit cy);
        cy  = 1'b0;
        nxt = s;
        case (op)
            1: begin
                if (s == 9) begin nxt = 0; cy = 1'b1; end
                else if (s > 9) nxt = 0;
                else nxt = s + 1;
            end
            2: nxt = data;
            3: nxt = 0;
            default: nxt = s;
        endcase
    endfunction

    always @(negedge clk) begin
        int win;
        bit found;
        int nxt;
        bit cy;
        logic [N-1:0]   exp_gnt;
        logic [4*N-1:0] exp_st;
        logic [N-1:0]   exp_cy;

        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin m_state[k] = 0; m_carry[k] = 1'b0; end
            m_rr = 0; m_done = 1'b0; m_done_id = 0; m_done_val = 0; m_done_carry = 1'b0;
            p_vld = 1'b0;
        end

        found = 1'b0;
        win = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[(m_rr + k) % N]) begin
                found = 1'b1;
                win = (m_rr + k) % N;
            end
        end
        exp_gnt = '0;
        if (found) exp_gnt[win] = 1'b1;
        for (int k = 0; k < N; k++) begin
            exp_st[4*k +: 4] = 4'(m_state[k]);
            exp_cy[k]        = m_carry[k];
        end

        chk("gnt_o", 32'(gnt_o), 32'(exp_gnt));
        chk("done_o", 32'(done_o), 32'(m_done));
        chk("done_id_o", 32'(done_id_o), 32'(m_done_id));
        chk("done_val_o", 32'(done_val_o), 32'(m_done_val));
        chk("done_carry_o", 32'(done_carry_o), 32'(m_done_carry));
        chk("state_o", 32'(state_o), 32'(exp_st));
        chk("carry_o", 32'(carry_o), 32'(exp_cy));

        if (done_o === 1'b1) begin
            log_id.push_back(int'(done_id_o));
            log_val.push_back(int'(done_val_o));
            log_carry.push_back(int'(done_carry_o));
        end

        if (rst_n) begin
            if (p_vld) begin
                bcd_eval(m_state[p_id], p_op, p_data, nxt, cy);
                m_state[p_id] = nxt;
                if (p_op != 0) m_carry[p_id] = cy;
                m_done = 1'b1; m_done_id = p_id; m_done_val = nxt; m_done_carry = cy;
            end else begin
                m_done = 1'b0;
            end
            if (found) begin
                p_vld  = 1'b1;
                p_id   = win;
                p_op   = int'(op_i[2*win +: 2]);
                p_data = int'(ld_data_i[4*win +: 4]);
                m_rr   = (win + 1) % N;
            end else begin
                p_vld = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_op(input int ch, input logic [1:0] op, input logic [3:0] data);
        op_i[2*ch +: 2]      = op;
        ld_data_i[4*ch +: 4] = data;
    endtask

    task automatic do_reset();
        req_i = '0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        log_id.delete();
        log_val.delete();
        log_carry.delete();
    endtask

    task automatic chk_log(input string name, input int ids[$], input int vals[$], input int cys[$]);
        chk({name, "_count"}, 32'(log_id.size()), 32'(ids.size()));
        for (int i = 0; i < ids.size() && i < log_id.size(); i++) begin
            chk({name, "_id"}, 32'(log_id[i]), 32'(ids[i]));
            chk({name, "_val"}, 32'(log_val[i]), 32'(vals[i]));
            chk({name, "_carry"}, 32'(log_carry[i]), 32'(cys[i]));
        end
    endtask

    initial begin
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("reset_state", 32'(state_o), 32'h0);
        chk("reset_carry", 32'(carry_o), 32'h0);
        chk("reset_done", 32'(done_o), 32'h0);

        // Ten INCs on ch0: 1..9 then wrap to 0 with carry.
        clear_log();
        set_op(0, 2'b01, 4'd0);
        req_i = 4'b0001;
        step(10);
        req_i = '0;
        step(3);
        chk_log("inc_seq", '{0,0,0,0,0,0,0,0,0,0}, '{1,2,3,4,5,6,7,8,9,0}, '{0,0,0,0,0,0,0,0,0,1});
        chk("inc_sticky_carry", 32'(carry_o[0]), 32'h1);
        set_op(0, 2'b11, 4'd0);
        req_i = 4'b0001;
        step(1);
        req_i = '0;
        step(3);
        chk("clear_carry", 32'(carry_o[0]), 32'h0);
        chk("clear_state", 32'(state_o[3:0]), 32'h0);

        // All four channels INC together: strict rotation.
        do_reset();
        clear_log();
        op_i  = 8'b01010101;
        req_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] exp_rot [4];
            exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
            #1;
            chk("rot_gnt", 32'(gnt_o), 32'(exp_rot[i % 4]));
            step(1);
        end
        req_i = '0;
        step(3);
        chk_log("rot", '{0,1,2,3,0,1,2,3}, '{1,1,1,1,2,2,2,2}, '{0,0,0,0,0,0,0,0});
        chk("rot_state", 32'(state_o), 32'h2222);

        // Illegal BCD load followed by INC resyncs to 0 without carry.
        clear_log();
        set_op(2, 2'b10, 4'd13);
        req_i = 4'b0100;
        step(1);
        set_op(2, 2'b01, 4'd0);
        step(1);
        req_i = '0;
        step(3);
        chk_log("load13", '{2,2}, '{13,0}, '{0,0});

        // LOAD 7 then READ on ch1.
        clear_log();
        set_op(1, 2'b10, 4'd7);
        req_i = 4'b0010;
        step(1);
        set_op(1, 2'b00, 4'd0);
        step(1);
        req_i = '0;
        step(3);
        chk_log("load_read", '{1,1}, '{7,7}, '{0,0});
        chk("read_state", 32'(state_o[7:4]), 32'h7);
        chk("read_carry", 32'(carry_o[1]), 32'h0);

        // Reset lands while ch3's INC is in the issue stage.
        clear_log();
        set_op(3, 2'b01, 4'd0);
        req_i = 4'b1000;
        step(1);
        req_i = '0;
        #1;
        rst_n = 1'b0;
        step(2);
        chk("abort_no_done", 32'(log_id.size()), 32'h0);
        chk("abort_state", 32'(state_o), 32'h0);
        chk("abort_done", 32'(done_o), 32'h0);
        rst_n = 1'b1;
        req_i = 4'b1111;
        #1;
        chk("abort_ptr0", 32'(gnt_o), 32'h1);
        req_i = 4'b1000;
        #1;
        chk("abort_gnt3", 32'(gnt_o), 32'h8);
        step(1);
        req_i = '0;
        step(3);
        chk_log("after_abort", '{3}, '{1}, '{0});

        // Pointer parked at 3 with sparse requests 0101.
        clear_log();
        set_op(0, 2'b00, 4'd0);
        set_op(2, 2'b00, 4'd0);
        req_i = 4'b0100;
        step(1);
        req_i = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            logic [3:0] exp_sp [3];
            exp_sp = '{4'b0001, 4'b0100, 4'b0001};
            #1;
            chk("sparse_gnt", 32'(gnt_o), 32'(exp_sp[i]));
            step(1);
        end
        req_i = '0;
        step(3);
        chk_log("sparse", '{2,0,2,0}, '{0,0,0,0}, '{0,0,0,0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decade_step_arbiter.md
Name: decade_step_arbiter

Overview:
- Shares one combinational BCD decade-step evaluator (4-bit decade counter next-state logic: count, load, clear, carry) between NREQ counter channels.
- Holds the per-channel 4-bit state registers and arbitrates requests round-robin, one operation per cycle.
- Registers each grant into a single issue stage and writes the result back with a completion pulse.
- Sits above the gate-level decade-step netlists as their sequencing and sharing controller.

Parameters:
NREQ, 4, number of requesting channels (2..16)
IDW, $clog2(NREQ), width of channel id fields

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_i  in  NREQ  per-channel request, level
op_i  in  2*NREQ  per-channel opcode; 00 READ, 01 INC, 10 LOAD, 11 CLEAR
ld_data_i  in  4*NREQ  per-channel load value
gnt_o  out  NREQ  one-hot grant, combinational from req_i and rr pointer
done_o  out  1  result-valid pulse
done_id_o  out  IDW  channel of completed op
done_val_o  out  4  channel state after op
done_carry_o  out  1  op produced a 9->0 wrap
state_o  out  4*NREQ  all channel states, registered
carry_o  out  NREQ  sticky per-channel carry flag

Behaviour:
- Reset, async on rst_n low: all states 0, carry_o 0, rr pointer 0, issue stage invalid, done_o 0, done_id_o 0, done_val_o 0, done_carry_o 0.
- Reset mid-operation discards any in-flight op: no done_o pulse, no writeback.
- Arbitration:
  - The winner is the first asserted req_i at or after the rr pointer, wrapping modulo NREQ.
  - gnt_o is one-hot for the winner; it is all zero when no req_i is asserted.
  - On a grant, the pointer moves to winner+1 mod NREQ at the clock edge.
  - With no request, the pointer holds.
- Handshake: an op is accepted at the edge where gnt_o is high. A requester keeping req_i high gets another op at its next round-robin turn. op_i and ld_data_i are sampled only for the granted channel.
- Pipeline:
  - Accept edge E: the issue stage captures {valid, id, op, ld_data}.
  - During the next cycle the evaluator reads state[id] and computes the result.
  - Edge E+1: state[id], carry_o[id] and the done_* outputs are written, and done_o is high for exactly that cycle.
  - Latency from grant to done is 1 cycle.
  - Throughput is 1 op per cycle.
  - Back-to-back ops on the same channel see the committed prior result; no forwarding is needed.
- Evaluator function, with s = current state:
  - INC: s in 0..8 gives s+1 with carry 0. s=9 gives 0 with carry 1. s in 10..15 (illegal BCD, reachable only by LOAD) gives 0 with carry 0.
  - LOAD: result = ld_data verbatim, including 10..15; carry 0.
  - CLEAR: result 0, carry 0.
  - READ: result = s, no state change, carry 0; done still pulses.
- carry_o[id]: set to 1 by an INC wrap. Cleared by any later INC/LOAD/CLEAR on that channel. READ leaves it unchanged.
- done_carry_o reflects only the op just completed.
- When done_o is low, the done_id_o, done_val_o and done_carry_o outputs hold their last values.
- Grant timing: a grant in the same cycle that a done pulse is produced for another channel is legal. The independent write ports serve different channel indices.

Decomposition:
- Shared package decade_pkg:
  - opcode enum: OP_READ=2'b00, OP_INC=2'b01, OP_LOAD=2'b10, OP_CLEAR=2'b11.
  - BCD_MAX=4'd9.
  - struct issue_t {valid, id, op, data}.
- Sub-module decade_step: purely combinational, inputs (s[3:0], op, ld_data[3:0]), outputs (nxt[3:0], carry). It is the shared evaluator and is instantiated once.
- Round-robin selection and state file stay in the top.

Test Plan:
- Reset then req_i=0001, op INC, held for 10 accepts -> ch0 done_val_o sequence 1..9,0. The 10th done has done_carry_o=1 and carry_o[0]=1. Then CLEAR -> carry_o[0]=0.
- req_i=1111, all INC, continuously for 8 cycles -> gnt_o sequence 0001,0010,0100,1000 repeating. Each done arrives 1 cycle after its grant with done_id_o 0,1,2,3,... Final state_o each channel 2.
- Ch2 LOAD 4'd13, then INC -> done_val_o 13 then 0, done_carry_o=0 on both.
- Ch1 LOAD 7, then READ -> done_val_o 7 twice; state_o[1] stays 7; carry_o[1] unchanged.
- Ch3 INC granted, rst_n pulled low in the following cycle before the edge -> no done_o, state_o all 0, pointer 0. After release, req_i=1000 is granted first-cycle.
- req_i=0101 with rr pointer at 3 -> ch0 granted first, then ch2, then ch0.
